// File: rtl/sipo_rx_if.sv
// Bundle of the serial-link and parallel-consumer signals around sipo_rx.
// The receiver takes the slave modport; the link/consumer side takes master.
interface sipo_rx_if #(
  parameter int WIDTH = 4
);
  logic             serial_in;
  logic             bit_valid;
  logic             frame_start;
  logic             data_ready;
  logic             clr_overrun;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             overrun;
  logic             busy;

  modport master (
    output serial_in,
    output bit_valid,
    output frame_start,
    output data_ready,
    output clr_overrun,
    input  data_out,
    input  data_valid,
    input  overrun,
    input  busy
  );

  modport slave (
    input  serial_in,
    input  bit_valid,
    input  frame_start,
    input  data_ready,
    input  clr_overrun,
    output data_out,
    output data_valid,
    output overrun,
    output busy
  );
endinterface

// File: rtl/sipo_rx.sv
// MSB-first serial-in parallel-out receiver with a valid/ready holding register
// and a sticky overrun flag for words dropped under back-pressure.
//
// Handshake: a word moves to the consumer on a rising edge where
// data_valid && data_ready; data_out is frozen while data_valid is high and
// the word has not been accepted.
module sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  sipo_rx_if.slave bus,
  output logic     state_dbg_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             overrun_q;
  logic             busy_q;

  logic [WIDTH-1:0] word_d;
  logic             start_d;
  logic             complete_d;
  logic             accept_d;
  logic             drop_d;

  always_comb begin
    word_d     = {shift_q[WIDTH-2:0], bus.serial_in};
    start_d    = bus.bit_valid && bus.frame_start;
    // frame_start takes priority over completion: a start bit always resyncs.
    complete_d = bus.bit_valid && !bus.frame_start &&
                 (state_q == SHIFT) && (cnt_q == LAST);
    accept_d   = valid_q && bus.data_ready;
    drop_d     = complete_d && valid_q && !bus.data_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_d) begin
            shift_q <= {{(WIDTH-1){1'b0}}, bus.serial_in};
            cnt_q   <= CW'(1);
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (start_d) begin
            shift_q <= {{(WIDTH-1){1'b0}}, bus.serial_in};
            cnt_q   <= CW'(1);
          end else if (complete_d) begin
            shift_q <= word_d;
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bus.bit_valid) begin
            shift_q <= word_d;
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // A completing word may replace one that is being accepted on this edge.
      if (complete_d && (!valid_q || accept_d)) begin
        data_q  <= word_d;
        valid_q <= 1'b1;
      end else if (accept_d) begin
        valid_q <= 1'b0;
      end

      if (drop_d) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = busy_q;
  assign state_dbg_o    = (state_q == SHIFT);

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx (WIDTH=4): frame-level reference model, per-cycle
// output compare, consumer-side word scoreboard and literal spot checks.
module tb_sipo_rx;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  logic state_dbg;

  sipo_rx_if #(.WIDTH(W)) bus ();

  sipo_rx #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          fbits[$];
  logic [W-1:0] exp_q[$];
  logic        m_busy, m_valid, m_ovr;
  logic [W-1:0] m_data;
  logic        m_done, m_acc, m_drop;
  logic [W-1:0] m_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fbits.delete();
      exp_q.delete();
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_data  = '0;
    end else begin
      m_done = 1'b0;
      m_word = '0;
      if (bus.bit_valid) begin
        if (bus.frame_start) begin
          fbits.delete();
          fbits.push_back(bus.serial_in);
          m_busy = 1'b1;
        end else if (m_busy) begin
          fbits.push_back(bus.serial_in);
          if (fbits.size() == W) begin
            foreach (fbits[i]) m_word = (m_word << 1) | W'(fbits[i]);
            fbits.delete();
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end
      m_acc  = m_valid && bus.data_ready;
      m_drop = m_done && m_valid && !bus.data_ready;
      if (m_done && !m_drop) begin
        m_data  = m_word;
        m_valid = 1'b1;
        exp_q.push_back(m_word);
      end else if (m_acc) begin
        m_valid = 1'b0;
      end
      if (m_drop) m_ovr = 1'b1;
      else if (bus.clr_overrun) m_ovr = 1'b0;
    end
  end

  // ---------------- per-cycle compare + consumer scoreboard ----------------
  always @(negedge clk) begin
    chk("busy", bus.busy, m_busy);
    chk("state_dbg", state_dbg, m_busy);
    chk("data_valid", bus.data_valid, m_valid);
    chk("overrun", bus.overrun, m_ovr);
    chk("data_out", bus.data_out, m_data);
    if (rst_n && m_valid && bus.data_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL consumer_word: word offered with empty expected queue at %0t", $time);
      end else begin
        chk("consumer_word", bus.data_out, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after the edge that consumed them.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    bus.serial_in   = b;
    bus.bit_valid   = 1'b1;
    bus.frame_start = fs;
    tick();
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.bit_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) send_bit(w[W-1-i], (i == 0));
  endtask

  task automatic accept_one();
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n           = 1'b0;
    bus.serial_in   = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.data_ready  = 1'b0;
    bus.clr_overrun = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_valid", bus.data_valid, 1'b0);
    chk("reset_data", bus.data_out, 4'h0);

    // Stray bits and a lone frame_start must not start a frame.
    send_bit(1'b1, 1'b0);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    chk("stray_busy", bus.busy, 1'b0);

    // Single frame held under back-pressure, then accepted.
    send_word(4'b1011);
    chk("single_data", bus.data_out, 4'b1011);
    chk("single_valid", bus.data_valid, 1'b1);
    idle(2);
    chk("single_hold", bus.data_out, 4'b1011);
    accept_one();
    chk("single_accepted", bus.data_valid, 1'b0);

    // Gapped bits: busy stays high across bit_valid gaps.
    for (int i = 0; i < W; i++) begin
      send_bit(W'(4'b0110) >> (W - 1 - i) & 1'b1, (i == 0));
      if (i < W - 1) begin
        idle(3);
        chk("gap_busy", bus.busy, 1'b1);
      end
    end
    chk("gap_data", bus.data_out, 4'b0110);
    chk("gap_busy_end", bus.busy, 1'b0);
    accept_one();

    // Resync: partial frame discarded without a flag.
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_word(4'b0001);
    chk("resync_data", bus.data_out, 4'b0001);
    chk("resync_ovr", bus.overrun, 1'b0);
    accept_one();

    // Back-pressure overrun, clear, and set-beats-clear.
    send_word(4'hA);
    send_word(4'h5);
    chk("bp_data", bus.data_out, 4'hA);
    chk("bp_ovr", bus.overrun, 1'b1);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    chk("bp_clr", bus.overrun, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    bus.clr_overrun = 1'b1;
    send_bit(1'b1, 1'b0);
    bus.clr_overrun = 1'b0;
    chk("bp_set_wins", bus.overrun, 1'b1);
    chk("bp_data_kept", bus.data_out, 4'hA);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    accept_one();
    chk("bp_drained", bus.data_valid, 1'b0);

    // Back-to-back frames with the consumer always ready.
    bus.data_ready = 1'b1;
    send_word(4'h3);
    chk("b2b_first", bus.data_out, 4'h3);
    send_bit(1'b1, 1'b1);
    chk("b2b_pulse", bus.data_valid, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("b2b_second", bus.data_out, 4'hC);
    chk("b2b_valid", bus.data_valid, 1'b1);
    tick();
    bus.data_ready = 1'b0;
    chk("b2b_ovr", bus.overrun, 1'b0);

    // Async reset mid-frame with a held word and overrun set.
    send_word(4'h9);
    send_word(4'h6);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("pre_rst_busy", bus.busy, 1'b1);
    chk("pre_rst_ovr", bus.overrun, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_valid", bus.data_valid, 1'b0);
    chk("rst_ovr", bus.overrun, 1'b0);
    chk("rst_data", bus.data_out, 4'h0);
    tick();
    rst_n = 1'b1;
    idle(2);
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
